// File: rtl/regfile_dump.sv
// Read-side dump sequencer: walks every register-file address through one async SRAM read port
// and streams the words out on a valid/ready channel. Define REGFILE_DUMP_CHECKSUM_EN for an XOR checksum tail beat.
module regfile_dump #(
    parameter int BUS_SIZE          = 32,
    parameter int DIR_SIZE_INTERNAL = 5,
    parameter int MEM_SIZE          = 32
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start,
    output logic [DIR_SIZE_INTERNAL-1:0] dirRead,
    input  logic [BUS_SIZE-1:0]          readData,
    output logic [BUS_SIZE-1:0]          outData,
    output logic                         outValid,
    input  logic                         outReady,
    output logic                         outLast,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   dbgState
);

    // Stream handshake: a beat transfers on a rising edge where outValid && outReady;
    // outData/outLast stay frozen while outValid is high and the beat has not transferred.

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN, TAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

    localparam logic [DIR_SIZE_INTERNAL-1:0] LAST_IDX = DIR_SIZE_INTERNAL'(MEM_SIZE - 1);

    state_t                         state;
    logic [DIR_SIZE_INTERNAL-1:0]   index;
    logic                           lastWord;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [BUS_SIZE-1:0]            checksum;
`endif

    // The SRAM address comes straight from a register so it never glitches.
    assign dirRead  = index;
    assign lastWord = (index == LAST_IDX);
    assign dbgState = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            index    <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                LOAD: begin
                    outData  <= readData;
                    outValid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    outLast  <= 1'b0;
                    checksum <= checksum ^ readData;
`else
                    outLast  <= lastWord;
`endif
                    state    <= SEND;
                end
                SEND: begin
                    if (outValid && outReady) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        if (lastWord) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // Checksum already holds the last word, folded in at its LOAD edge.
                            outData  <= checksum;
                            outValid <= 1'b1;
                            outLast  <= 1'b1;
                            state    <= TAIL;
`else
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
`endif
                        end else begin
                            index <= index + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                TAIL: begin
                    if (outValid && outReady) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FIN;
                    end
                end
`endif
                FIN: begin
                    // start is deliberately not looked at here.
                    index   <= '0;
                    outLast <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: SRAM array model, snapshot-based expected beat queue, per-cycle compare process.
// Follows REGFILE_DUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dump;

    localparam int W = 32;
    localparam int N = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int TOTAL = N + 1;
    localparam int LAT   = 2 * N + 1;
`else
    localparam int TOTAL = N;
    localparam int LAT   = 2 * N;
`endif

    logic         clk = 1'b0;
    logic         resetN;
    logic         start;
    logic [4:0]   dirRead;
    logic [W-1:0] readData;
    logic [W-1:0] outData;
    logic         outValid;
    logic         outReady;
    logic         outLast;
    logic         busy;
    logic         done;
    logic [2:0]   dbgState;

    logic [W-1:0] mem [N];
    logic [W-1:0] snap [N];
    logic [W-1:0] exp_q[$];

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int beatIdx = 0;
    int beatBase = 0;
    int doneCount = 0;
    int doneBase = 0;
    int acceptCyc = 0;
    int readyMode = 0;
    bit checkLatency = 0;
    bit holdPending = 0;
    bit prevDone = 0;
    logic [W-1:0] holdData;
    logic holdLast;

    regfile_dump #(.BUS_SIZE(W), .DIR_SIZE_INTERNAL(5), .MEM_SIZE(N)) dut (
        .clk(clk), .resetN(resetN), .start(start), .dirRead(dirRead),
        .readData(readData), .outData(outData), .outValid(outValid),
        .outReady(outReady), .outLast(outLast), .busy(busy), .done(done),
        .dbgState(dbgState)
    );

    // clock / SRAM read port
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign readData = mem[dirRead];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        nCompared++;
        if (got !== expv) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nCompared++;
        nMismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Consumer ready pattern, changed just after each rising edge.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: outReady = 1'b1;
                1: outReady = (cyc % 3 == 0);
                2: outReady = 1'($urandom_range(0, 1));
                default: outReady = 1'b0;
            endcase
        end
    end

    // Compare process: beats, hold stability, done pulse.
    always @(negedge clk) begin
        if (resetN) begin
            if (holdPending) begin
                check("hold_valid", 32'(outValid), 32'd1);
                check("hold_data", outData, holdData);
                check("hold_last", 32'(outLast), 32'(holdLast));
            end
            holdPending = outValid && !outReady;
            holdData = outData;
            holdLast = outLast;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) fail_now("extra_beat");
                else begin
                    check("beat_data", outData, exp_q.pop_front());
                    check("beat_last", 32'(outLast), 32'(beatIdx - beatBase == TOTAL - 1));
                    beatIdx++;
                end
            end
            if (done) begin
                doneCount++;
                check("done_beats", 32'(beatIdx - beatBase), 32'(TOTAL));
                check("done_busy", 32'(busy), 32'd0);
                if (checkLatency) check("done_latency", 32'(cyc - acceptCyc), 32'(LAT));
                if (prevDone) fail_now("done_two_cycles");
            end
            prevDone = done;
        end else begin
            holdPending = 0;
            prevDone = 0;
        end
    end

    // mode 0: i*0x01010101, 1: random, 2: checksum pattern
    task automatic preload(input int mode);
        logic [W-1:0] v;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: v = i * 32'h01010101;
                1: v = $urandom;
                default: v = (i == 3) ? 32'hA5A5A5A5 : (i == 9) ? 32'h0F0F0F0F : 32'h0;
            endcase
            mem[i] <= v;
            snap[i] = v;
        end
        @(negedge clk);
    endtask

    // Expected stream: each word in address order, then the XOR of all words if enabled.
    task automatic build_expected();
        logic [W-1:0] acc = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(snap[i]);
            acc ^= snap[i];
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back(acc);
`endif
    endtask

    // Returns at the falling edge after the first LOAD edge.
    task automatic dump_start();
        beatBase = beatIdx;
        doneBase = doneCount;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acceptCyc = cyc;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(outValid), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (doneCount == doneBase && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) fail_now("done_timeout");
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        check("done_once", 32'(doneCount - doneBase), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(outValid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic dump(input int mode, input bit lat);
        readyMode = mode;
        checkLatency = lat;
        dump_start();
        wait_done(2000);
        checkLatency = 0;
        settle();
    endtask

    initial begin
        int k;
        int abortBase;
        resetN = 1'b0;
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] <= '0;
        #12;
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_last", 32'(outLast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_dir", 32'(dirRead), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Full dump with ready held high, then with 1-of-3 ready.
        preload(0);
        build_expected();
        check("model_beat5", exp_q[5], 32'h05050505);
        check("model_beat31", exp_q[N-1], 32'h1F1F1F1F);
        dump(0, 1);
        build_expected();
        dump(1, 0);

        // start pulsed again around beat 10 is ignored.
        build_expected();
        readyMode = 2;
        dump_start();
        k = 0;
        while (beatIdx - beatBase < 10 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) fail_now("beat10_timeout");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000);
        settle();

        // start during the done cycle is ignored.
        build_expected();
        readyMode = 0;
        dump_start();
        repeat (LAT - 1) @(negedge clk);
        check("fin_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        settle();

        // Asynchronous reset at beat 5 while the beat is held.
        preload(1);
        build_expected();
        readyMode = 1;
        dump_start();
        k = 0;
        while (!(beatIdx - beatBase >= 5 && outValid && !outReady) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) fail_now("beat5_timeout");
        abortBase = doneCount;
        #2 resetN = 1'b0;
        #1;
        check("abort_valid", 32'(outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dir", 32'(dirRead), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_nodone", 32'(doneCount - abortBase), 32'd0);
        build_expected();
        dump(2, 0);

        // SRAM write ahead of the LOAD of index 7 is seen.
        preload(0);
        snap[7] = 32'hDEADBEEF;
        build_expected();
        check("model_new7", exp_q[7], 32'hDEADBEEF);
        readyMode = 0;
        dump_start();
        mem[7] <= 32'hDEADBEEF;
        wait_done(2000);
        settle();

        // Same write on the LOAD edge of index 7 returns the old word.
        preload(0);
        build_expected();
        check("model_old7", exp_q[7], 32'h07070707);
        dump_start();
        repeat (13) @(negedge clk);
        @(posedge clk);
        mem[7] <= 32'hDEADBEEF;
        wait_done(2000);
        settle();

        // Random contents under random backpressure.
        repeat (3) begin
            preload(1);
            build_expected();
            dump(2, 0);
        end

`ifdef REGFILE_DUMP_CHECKSUM_EN
        preload(2);
        build_expected();
        check("model_sum_size", 32'(exp_q.size()), 32'd33);
        check("model_sum", exp_q[N], 32'hAAAAAAAA);
        dump(0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "watchdog");
    end

endmodule
